// File: rtl/regfile_mp.sv
// ============================================================================
//  Module      : regfile_mp
//  Description : Multi-port general-purpose register file with two write
//                ports (W0 = ALU writeback, W1 = load/long-latency writeback)
//                and a per-register pending scoreboard for the ID stage.
//                Optional feature macro: REGFILE_BYPASS_EN (internal
//                forwarding of same-cycle writes to the read ports).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 32,
    parameter int                    NUM_RD     = 2,
    parameter int                    SP_IDX     = 29,
    parameter logic [DATA_WIDTH-1:0] SP_RESET   = 'hfff,
    localparam int                   AW         = $clog2(NUM_REGS)
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [NUM_RD*AW-1:0]         raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]            rbusy,
    input  logic                         wen0,
    input  logic [AW-1:0]                waddr0,
    input  logic [DATA_WIDTH-1:0]        wdata0,
    input  logic                         wen1,
    input  logic [AW-1:0]                waddr1,
    input  logic [DATA_WIDTH-1:0]        wdata1,
    input  logic                         issue_en,
    input  logic [AW-1:0]                issue_addr,
    input  logic                         flush,
    output logic                         any_busy
);

    // Register 0 has no storage; index 0 of these arrays is never used.
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS-1:1];
    logic [NUM_REGS-1:1]   r_pend;

    // Read-side views with register 0 folded in as a constant zero / idle.
    logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   w_pend;

    // Register storage: W1 is applied after W0 so it wins on an address clash.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (i == SP_IDX) r_regs[i] <= SP_RESET;
                else             r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wen1 && (waddr1 == AW'(i)))      r_regs[i] <= wdata1;
                else if (wen0 && (waddr0 == AW'(i))) r_regs[i] <= wdata0;
            end
        end
    end

    // Pending scoreboard: flush beats issue, issue beats the W1 clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pend <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (flush)                                r_pend[i] <= 1'b0;
                else if (issue_en && (issue_addr == AW'(i))) r_pend[i] <= 1'b1;
                else if (wen1 && (waddr1 == AW'(i)))      r_pend[i] <= 1'b0;
            end
        end
    end

    // Build the zero-extended read views of storage and scoreboard.
    always_comb begin
        w_regs[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            w_regs[i] = r_regs[i];
        end
        w_pend = {r_pend, 1'b0};
    end

    assign any_busy = |r_pend;

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [AW-1:0]         w_ra;
            logic [DATA_WIDTH-1:0] w_data;
            logic                  w_busy;

            assign w_ra = raddr[k*AW +: AW];

            // Combinational read of port k, optionally forwarding same-cycle writes.
            always_comb begin
                w_data = w_regs[w_ra];
                w_busy = w_pend[w_ra];
`ifdef REGFILE_BYPASS_EN
                if (w_ra != '0) begin
                    if (wen1 && (waddr1 == w_ra)) begin
                        w_data = wdata1;
                        w_busy = 1'b0;
                    end else if (wen0 && (waddr0 == w_ra)) begin
                        w_data = wdata0;
                    end
                end
`endif
            end

            assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = w_data;
            assign rbusy[k]                          = w_busy;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Self-checking bench for regfile_mp: directed scenarios plus
//                randomized traffic compared against an array-based model.
//                Honours REGFILE_BYPASS_EN in the model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int RD = 4;
    localparam int AW = 5;
    localparam logic [DW-1:0] SPV = 32'hfff;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic [RD*AW-1:0]  raddr;
    logic [RD*DW-1:0]  rdata;
    logic [RD-1:0]     rbusy;
    logic              wen0, wen1, issue_en, flush;
    logic [AW-1:0]     waddr0, waddr1, issue_addr;
    logic [DW-1:0]     wdata0, wdata1;
    logic              any_busy;

    logic [AW-1:0]     ra [RD];

    logic [DW-1:0]     m_mem  [NR];
    bit                m_pend [NR];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    always_comb begin
        raddr = '0;
        for (int k = 0; k < RD; k++) raddr[k*AW +: AW] = ra[k];
    end

    regfile_mp #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .NUM_RD     (RD),
        .SP_IDX     (29),
        .SP_RESET   (SPV)
    ) u_dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .raddr      (raddr),
        .rdata      (rdata),
        .rbusy      (rbusy),
        .wen0       (wen0),
        .waddr0     (waddr0),
        .wdata0     (wdata0),
        .wen1       (wen1),
        .waddr1     (waddr1),
        .wdata1     (wdata1),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .flush      (flush),
        .any_busy   (any_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_mem[i]  = (i == 29) ? SPV : '0;
            m_pend[i] = 1'b0;
        end
    endtask

    // Sequential effect of one clock edge: W0 first, W1 overwrites; pending
    // cleared by W1, then set by issue (newer producer), flush clears all.
    task automatic model_update();
        if (wen0 && waddr0 != 0) m_mem[waddr0] = wdata0;
        if (wen1 && waddr1 != 0) m_mem[waddr1] = wdata1;
        if (flush) begin
            for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
        end else begin
            if (wen1 && waddr1 != 0)         m_pend[waddr1]     = 1'b0;
            if (issue_en && issue_addr != 0) m_pend[issue_addr] = 1'b1;
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wen1 && waddr1 == a) return wdata1;
        if (wen0 && waddr0 == a) return wdata0;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wen1 && waddr1 == a) return 1'b0;
`endif
        return m_pend[a];
    endfunction

    function automatic logic exp_any();
        logic r = 1'b0;
        for (int i = 1; i < NR; i++) r |= m_pend[i];
        return r;
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < RD; k++) begin
            chk($sformatf("%s_rdata%0d", tag, k), 64'(rdata[k*DW +: DW]), 64'(exp_data(ra[k])));
            chk($sformatf("%s_rbusy%0d", tag, k), 64'(rbusy[k]), 64'(exp_busy(ra[k])));
        end
        chk($sformatf("%s_any", tag), 64'(any_busy), 64'(exp_any()));
    endtask

    task automatic idle();
        wen0 = 0; wen1 = 0; issue_en = 0; flush = 0;
        waddr0 = '0; waddr1 = '0; issue_addr = '0;
        wdata0 = '0; wdata1 = '0;
    endtask

    // Called just after a falling edge with inputs driven: check, then clock.
    task automatic step(input string tag);
        #1 check_all(tag);
        @(posedge CLK);
        if (RST_N) model_update();
        @(negedge CLK);
    endtask

    // Scan every register through the read ports while reset is held.
    task automatic reset_scan(input string tag);
        for (int b = 0; b < NR; b += RD) begin
            for (int k = 0; k < RD; k++) ra[k] = AW'(b + k);
            #1 check_all(tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] old3;
        idle();
        for (int k = 0; k < RD; k++) ra[k] = '0;
        RST_N = 1'b1;

        // 1: reset dropped mid-cycle, visible immediately
        #3 RST_N = 1'b0;
        model_reset();
        reset_scan("t1_reset");
        @(negedge CLK);
        RST_N = 1'b1;

        // 2: dual write to reg 5, W1 wins; reg 0 write ignored
        wen0 = 1; waddr0 = 5; wdata0 = 32'h11;
        wen1 = 1; waddr1 = 5; wdata1 = 32'h22;
        ra[0] = 5; ra[1] = 29; ra[2] = 0; ra[3] = 1;
        step("t2_dual");
        idle();
        #1 chk("t2_w1wins", 64'(rdata[0 +: DW]), 64'h22);
        wen0 = 1; waddr0 = 0; wdata0 = 32'hdead;
        ra[0] = 0;
        step("t2_wr0");
        idle();
        #1 chk("t2_reg0", 64'(rdata[0 +: DW]), 64'h0);

        // 3: scoreboard set by issue, released the cycle after W1
        issue_en = 1; issue_addr = 8; ra[0] = 8;
        step("t3_issue");
        idle(); ra[0] = 8;
        #1 chk("t3_busy", 64'(rbusy[0]), 64'h1);
        chk("t3_any", 64'(any_busy), 64'h1);
        wen1 = 1; waddr1 = 8; wdata1 = 32'h88;
        step("t3_w1");
        idle();
        #1 chk("t3_release", 64'(rbusy[0]), 64'h0);
        chk("t3_data", 64'(rdata[0 +: DW]), 64'h88);

        // 4: issue and W1 clear on same reg -> stays busy; flush beats issue
        issue_en = 1; issue_addr = 8; wen1 = 1; waddr1 = 8; wdata1 = 32'h99;
        step("t4_coll");
        idle();
        #1 chk("t4_stays", 64'(rbusy[0]), 64'h1);
        flush = 1; issue_en = 1; issue_addr = 9; ra[1] = 9;
        step("t4_flush");
        idle();
        #1 chk("t4_flush_any", 64'(any_busy), 64'h0);
        chk("t4_flush_9", 64'(rbusy[1]), 64'h0);

        // 5: same-cycle visibility of a W0 write
        ra[0] = 3;
        #1 old3 = m_mem[3];
        wen0 = 1; waddr0 = 3; wdata0 = 32'hAB;
`ifdef REGFILE_BYPASS_EN
        #1 chk("t5_bypass", 64'(rdata[0 +: DW]), 64'hAB);
`else
        #1 chk("t5_nobypass", 64'(rdata[0 +: DW]), 64'(old3));
`endif
        step("t5_wr");
        idle();
        #1 chk("t5_next", 64'(rdata[0 +: DW]), 64'hAB);

        // 6: four ports reading distinct regs; issue on reg 0 is ignored
        for (int i = 1; i <= 4; i++) begin
            wen0 = 1; waddr0 = AW'(i); wdata0 = 32'h100 * i;
            step("t6_fill");
        end
        idle();
        for (int k = 0; k < RD; k++) ra[k] = AW'(4 - k);
        issue_en = 1; issue_addr = 0;
        step("t6_read");
        idle();
        #1 chk("t6_reg0_issue", 64'(any_busy), 64'h0);
        chk("t6_port3", 64'(rdata[3*DW +: DW]), 64'h100);

        // Randomized traffic with one asynchronous reset mid-stream
        for (int c = 0; c < 2000; c++) begin
            wen0       = ($urandom_range(0, 1) == 1);
            wen1       = ($urandom_range(0, 2) == 0);
            issue_en   = ($urandom_range(0, 2) == 0);
            flush      = ($urandom_range(0, 31) == 0);
            waddr0     = AW'($urandom_range(0, 7));
            waddr1     = AW'($urandom_range(0, 7));
            issue_addr = AW'($urandom_range(0, 7));
            wdata0     = $urandom;
            wdata1     = $urandom;
            for (int k = 0; k < RD; k++)
                ra[k] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            if (c == 1000) begin
                #2 RST_N = 1'b0;
                idle();
                model_reset();
                reset_scan("rnd_reset");
                @(negedge CLK);
                RST_N = 1'b1;
            end else begin
                step("rnd");
            end
        end

        idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
